// File: rtl/controle_muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | controle_muldiv_if                                                   |
// | Decode-side request/response bundle for the HI/LO mul/div sequencer. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface controle_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       fnsel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             rdhilo;
   logic             wrhi;
   logic             wrlo;
   logic [WIDTH-1:0] wdata;
   logic             flush;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             divzero;
   logic             stall;

   modport master (
      output start, fnsel, a, b, rdhilo, wrhi, wrlo, wdata, flush,
      input  hi, lo, busy, done, divzero, stall
   );

   modport slave (
      input  start, fnsel, a, b, rdhilo, wrhi, wrlo, wdata, flush,
      output hi, lo, busy, done, divzero, stall
   );
endinterface
`default_nettype wire

// File: rtl/controle_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | controle_muldiv                                                      |
// | Multi-cycle shift-add multiply / restoring divide owning HI and LO.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module controle_muldiv #(
   parameter int WIDTH = 32
) (
   input  wire logic          clock,
   input  wire logic          reset,
   controle_muldiv_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         fn_q, fn_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sgn_res_q, sgn_res_d;
   logic               sgn_rem_q, sgn_rem_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               is_div;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rmd;
   logic               mt_ok;

   always_comb begin
      is_div    = fn_q[1];
      // fnsel[0] clear selects the signed variant of both mul and div
      neg_a     = ~fn_q[0] & a_q[WIDTH-1];
      neg_b     = ~fn_q[0] & b_q[WIDTH-1];
      abs_a     = neg_a ? -a_q : a_q;
      abs_b     = neg_b ? -b_q : b_q;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
      div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      prod      = sgn_res_q ? -acc_q : acc_q;
      quo       = sgn_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rmd       = sgn_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      mt_ok     = (state_q == S_IDLE) || (state_q == S_DONE);
   end

   always_comb begin
      state_d   = state_q;
      fn_d      = fn_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      sgn_res_d = sgn_res_q;
      sgn_rem_d = sgn_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start && !bus.flush) begin
               fn_d    = bus.fnsel;
               a_d     = bus.a;
               b_d     = bus.b;
               dz_d    = 1'b0;
               state_d = S_PREP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (is_div && (b_q == '0)) begin
               hi_d    = a_q;
               lo_d    = '1;
               dz_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               a_d       = abs_a;
               b_d       = abs_b;
               sgn_res_d = neg_a ^ neg_b;
               sgn_rem_d = neg_a;
               acc_d     = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               if (is_div) begin
                  // restore by keeping the shifted value when the trial subtract borrows
                  rem_d = div_diff[WIDTH] ? div_shift : div_diff;
                  acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
               end else if (acc_q[0]) begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end else begin
                  acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               if (is_div) begin
                  hi_d = rmd;
                  lo_d = quo;
               end else begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (mt_ok && bus.wrhi) begin
         hi_d = bus.wdata;
      end
      if (mt_ok && bus.wrlo) begin
         lo_d = bus.wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         fn_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         sgn_res_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         fn_q      <= fn_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         sgn_res_q <= sgn_res_d;
         sgn_rem_q <= sgn_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   logic busy;
   assign busy        = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
   assign bus.busy    = busy;
   assign bus.done    = (state_q == S_DONE);
   assign bus.divzero = (state_q == S_DONE) && dz_q;
   assign bus.stall   = busy & (bus.start | bus.rdhilo | bus.wrhi | bus.wrlo);
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
endmodule
`default_nettype wire
